// File: rtl/csa_resolve.sv
// ---------------------------------------------------------------------------
// csa_resolve
//   Resolves a carry-save pair (sum vector + carry vector) into its exact
//   binary value. The add runs over several cycles, CHUNK bits per cycle,
//   with the inter-chunk carry kept in a flop. This keeps the adder short.
//   Valid/ready handshake on both sides; one operation in flight at a time.
//
// Ports
//   clk        in   1          clock, all state on rising edge
//   rst_n      in   1          synchronous active-low reset
//   in_valid   in   1          in_sum/in_carry valid
//   in_ready   out  1          block can accept an operand pair (IDLE)
//   in_sum     in   WIDTH      sum vector, bit i weight 2^i
//   in_carry   in   WIDTH      carry vector, bit i weight 2^(i+1)
//   out_valid  out  1          out_value holds a finished result (DONE)
//   out_ready  in   1          consumer accepts out_value
//   out_value  out  WIDTH+2    in_sum + (in_carry << 1), unsigned
// ---------------------------------------------------------------------------
module csa_resolve #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_sum,
  input  logic [WIDTH-1:0]   in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   out_value
);

  localparam int W2 = WIDTH + 2;
  // Number of chunk steps; operands are zero-padded up to N*CHUNK bits.
  localparam int N  = (W2 + CHUNK - 1) / CHUNK;
  localparam int PW = N * CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   a_q;
  logic [PW-1:0]   b_q;
  logic [PW-1:0]   r_q;
  logic [PW-1:0]   r_d;
  logic [IW-1:0]   idx_q;
  logic            cy_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W2-1:0]   out_value_q;
  logic [CHUNK:0]  chunk_sum_s;
  int              base_s;

  // One chunk of the carry-propagate add and the result vector it produces.
  always_comb begin
    base_s      = int'(idx_q) * CHUNK;
    chunk_sum_s = {1'b0, a_q[base_s +: CHUNK]}
                + {1'b0, b_q[base_s +: CHUNK]}
                + {{CHUNK{1'b0}}, cy_q};
    r_d                     = r_q;
    r_d[base_s +: CHUNK]    = chunk_sum_s[CHUNK-1:0];
  end

  // Control FSM, operand/result storage and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            // Sum has weight 2^i; carry is pre-shifted to weight 2^(i+1).
            a_q        <= {{(PW-WIDTH){1'b0}}, in_sum};
            b_q        <= {{(PW-WIDTH-1){1'b0}}, in_carry, 1'b0};
            r_q        <= '0;
            idx_q      <= '0;
            cy_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_q  <= r_d;
          cy_q <= chunk_sum_s[CHUNK];
          if (idx_q == LAST_IDX) begin
            // The full result fits in W2 bits, so the final carry is zero.
            out_value_q <= r_d[W2-1:0];
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          // No bypass: a new operand is only taken once back in IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          idx_q       <= '0;
          cy_q        <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;

endmodule

// File: tb/tb_csa_resolve.sv
// ---------------------------------------------------------------------------
// tb_csa_resolve
//   Scoreboard bench for csa_resolve. An input monitor pushes the expected
//   value (sum + 2*carry) and the handshake edge number into a queue; an
//   output monitor pops and compares value and latency. A default instance
//   (CHUNK=2) takes directed and random traffic; three more instances
//   (CHUNK=1,3,10) take random traffic with random backpressure.
// ---------------------------------------------------------------------------
module tb_csa_resolve;

  localparam int WIDTH = 8;
  localparam int W2    = WIDTH + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  // Edge counter: at any time after edge E settles, cyc == E.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned val;
    int unsigned edge_n;
  } exp_t;

  function automatic int unsigned ref_value(int unsigned s, int unsigned c);
    return s + 2 * c;
  endfunction

  function automatic int unsigned steps(int chunk);
    return (W2 + chunk - 1) / chunk;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ------------------------------------------------------------ main DUT
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum = '0;
  logic [WIDTH-1:0] in_carry = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W2-1:0]    out_value;
  bit               rand_or = 1'b0;

  csa_resolve #(.WIDTH(WIDTH), .CHUNK(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value)
  );

  exp_t          exp_q[$];
  logic          prev_ov = 1'b0;
  logic          prev_or = 1'b0;
  logic [W2-1:0] prev_val = '0;
  logic          expect_drop = 1'b0;

  // Scoreboard for the main DUT: inputs at the next edge are visible here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      expect_drop = 1'b0;
      prev_ov     = 1'b0;
    end else begin
      check("ready_valid_exclusive", longint'(in_ready && out_valid), 0);
      if (prev_ov && !prev_or) begin
        check("valid_held", out_valid, 1);
        check("value_held", out_value, prev_val);
      end
      if (expect_drop) begin
        check("valid_drops_after_accept", out_valid, 0);
        expect_drop = 1'b0;
      end
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("latency", cyc, exp_q[0].edge_n + steps(2));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", out_value, e.val);
        end
        expect_drop = 1'b1;
      end
      if (in_valid && in_ready) begin
        e.val    = ref_value(in_sum, in_carry);
        e.edge_n = cyc + 1;
        exp_q.push_back(e);
      end
      prev_ov = out_valid;
    end
    prev_or  = out_ready;
    prev_val = out_value;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and return once it has been taken (edge number in acc).
  task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                      output int unsigned acc);
    int t = 0;
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
      tick();
      t++;
    end
    if (t >= 200) check("send_timeout", t, 0);
    acc = cyc + 1;
    tick();
  endtask

  task automatic wait_out();
    int t = 0;
    while (!out_valid && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check("out_valid_timeout", t, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check("idle_timeout", t, 0);
  endtask

  // ------------------------------------------------------------ sweep DUTs
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 3 : 10);
    logic             s_rst_n = 1'b0;
    logic             s_in_valid = 1'b0;
    logic             s_in_ready;
    logic [WIDTH-1:0] s_sum = '0;
    logic [WIDTH-1:0] s_carry = '0;
    logic             s_out_valid;
    logic             s_out_ready = 1'b0;
    logic [W2-1:0]    s_out_value;
    bit               done = 1'b0;
    exp_t             sq[$];
    logic             s_prev_ov = 1'b0;

    csa_resolve #(.WIDTH(WIDTH), .CHUNK(CH)) u_sweep (
      .clk       (clk),
      .rst_n     (s_rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_sum    (s_sum),
      .in_carry  (s_carry),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_value (s_out_value)
    );

    // Scoreboard for this sweep instance.
    always @(negedge clk) begin
      exp_t e;
      if (s_rst_n) begin
        check("sweep_exclusive", longint'(s_in_ready && s_out_valid), 0);
        if (s_out_valid && !s_prev_ov) begin
          if (sq.size() == 0) check("sweep_unexpected_valid", 1, 0);
          else check("sweep_latency", cyc, sq[0].edge_n + steps(CH));
        end
        if (s_out_valid && s_out_ready) begin
          if (sq.size() == 0) begin
            check("sweep_unexpected_result", 1, 0);
          end else begin
            e = sq.pop_front();
            check("sweep_result", s_out_value, e.val);
          end
        end
        if (s_in_valid && s_in_ready) begin
          e.val    = ref_value(s_sum, s_carry);
          e.edge_n = cyc + 1;
          sq.push_back(e);
        end
        s_prev_ov = s_out_valid;
      end
    end

    // Random traffic with random backpressure and idle gaps.
    initial begin
      int t;
      repeat (2) @(posedge clk);
      #1 s_rst_n = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        s_sum      = WIDTH'($urandom());
        s_carry    = WIDTH'($urandom());
        s_in_valid = 1'($urandom_range(0, 3) != 0);
        t = 0;
        while (!(s_in_valid && s_in_ready) && t < 200) begin
          s_out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          s_in_valid = 1'b1;
          t++;
        end
        if (t >= 200) check("sweep_send_timeout", t, 0);
        @(posedge clk);
        #1;
        s_in_valid  = 1'b0;
        s_sum       = WIDTH'($urandom());
        s_carry     = WIDTH'($urandom());
        s_out_ready = 1'($urandom_range(0, 1));
      end
      s_out_ready = 1'b1;
      t = 0;
      while (!s_in_ready && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("sweep_drained", sq.size(), 0);
      done = 1'b1;
    end
  end

  // ------------------------------------------------------------ directed
  initial begin
    int unsigned k, e0, e1, e2;
    int t;

    // Reset with in_valid asserted: nothing may be captured.
    in_valid = 1'b1;
    in_sum   = 8'hA5;
    in_carry = 8'h5A;
    rst_n    = 1'b0;
    tick();
    tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_value", out_value, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    tick();
    check("post_reset_no_output", out_valid, 0);

    // Maximum operands.
    out_ready = 1'b1;
    send(8'hFF, 8'hFF, k);
    in_valid = 1'b0;
    wait_out();
    check("max_value", out_value, 10'h2FD);
    check("max_latency", cyc, k + 5);
    wait_idle();

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    send(8'h5A, 8'h0F, k);
    in_valid = 1'b1;
    in_sum   = 8'h11;
    wait_out();
    for (int i = 0; i < 10; i++) begin
      check("bp_value", out_value, 10'h078);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // Reset at the third BUSY edge discards the operation.
    send(8'hA5, 8'h3C, k);
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midbusy_reset_idle", in_ready, 1);
    check("midbusy_reset_valid", out_valid, 0);
    repeat (8) tick();
    send(8'h01, 8'h01, k);
    in_valid = 1'b0;
    wait_out();
    check("after_reset_value", out_value, 3);
    wait_idle();

    // Back-to-back with in_valid held high.
    send(8'h00, 8'h00, e0);
    send(8'h01, 8'h80, e1);
    send(8'hFF, 8'h00, e2);
    in_valid = 1'b0;
    check("b2b_spacing_1", e1 - e0, 7);
    check("b2b_spacing_2", e2 - e1, 7);
    wait_idle();
    repeat (3) tick();

    // Random traffic on the main DUT.
    rand_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(WIDTH'($urandom()), WIDTH'($urandom()), k);
      in_valid = 1'($urandom_range(0, 1));
      in_sum   = WIDTH'($urandom());
      tick();
    end
    rand_or   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    tick();
    check("main_drained", exp_q.size(), 0);

    // Wait for the sweep instances.
    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 60000) begin
      tick();
      t++;
    end
    if (t >= 60000) check("sweep_timeout", t, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
